// File: rtl/plic_target_core.sv
// PLIC per-target core: pending latches, priority resolver and claim/complete.
// Drives gateway ready so a source re-arms only after its completion.
module plic_target_core #(
  parameter int NUM_SOURCES    = 8,
  parameter int PRIORITY_WIDTH = 3,
  parameter int ID_WIDTH       = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_SOURCES-1:0]                interrupt_source_request_i,
  output logic [NUM_SOURCES-1:0]                interrupt_target_ready_o,
  input  logic [NUM_SOURCES*PRIORITY_WIDTH-1:0] source_priority_i,
  input  logic [NUM_SOURCES-1:0]                source_enable_i,
  input  logic [PRIORITY_WIDTH-1:0]             target_threshold_i,
  input  logic                                  claim_i,
  output logic [ID_WIDTH-1:0]                   claim_id_o,
  output logic                                  claim_valid_o,
  input  logic                                  complete_i,
  input  logic [ID_WIDTH-1:0]                   complete_id_i,
  output logic [NUM_SOURCES-1:0]                pending_o,
  output logic                                  interrupt_notification_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_SERV
  } src_state_e;

  src_state_e state_q [NUM_SOURCES];

  logic [ID_WIDTH-1:0]       best_id_q;
  logic [PRIORITY_WIDTH-1:0] best_prio_q;
  logic [ID_WIDTH-1:0]       best_id_c;
  logic [PRIORITY_WIDTH-1:0] best_prio_c;

  always_comb begin
    for (int k = 0; k < NUM_SOURCES; k++) begin
      pending_o[k]                = (state_q[k] == S_PEND);
      interrupt_target_ready_o[k] = (state_q[k] == S_IDLE);
    end
  end

  // Strict compare while scanning upward keeps the lowest ID on ties.
  always_comb begin
    best_id_c   = '0;
    best_prio_c = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (state_q[k] == S_PEND && source_enable_i[k] &&
          source_priority_i[k*PRIORITY_WIDTH +: PRIORITY_WIDTH]
            > best_prio_c) begin
        best_prio_c =
          source_priority_i[k*PRIORITY_WIDTH +: PRIORITY_WIDTH];
        best_id_c   = ID_WIDTH'(k + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        state_q[k] <= S_IDLE;
      end
      best_id_q                <= '0;
      best_prio_q              <= '0;
      claim_id_o               <= '0;
      claim_valid_o            <= 1'b0;
      interrupt_notification_o <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        unique case (state_q[k])
          S_IDLE: begin
            if (interrupt_source_request_i[k]) begin
              state_q[k] <= S_PEND;
            end
          end
          S_PEND: begin
            if (claim_i && best_id_q == ID_WIDTH'(k + 1)) begin
              state_q[k] <= S_SERV;
            end
          end
          S_SERV: begin
            if (complete_i && complete_id_i == ID_WIDTH'(k + 1)) begin
              state_q[k] <= S_IDLE;
            end
          end
          default: state_q[k] <= S_IDLE;
        endcase
      end

      claim_valid_o <= claim_i;
      if (claim_i) begin
        claim_id_o  <= best_id_q;
        best_id_q   <= '0;
        best_prio_q <= '0;
      end else begin
        best_id_q   <= best_id_c;
        best_prio_q <= best_prio_c;
      end

      interrupt_notification_o <= (best_prio_q > target_threshold_i);
    end
  end

endmodule

// File: tb/tb_plic_target_core.sv
// Directed bench for plic_target_core.
// Expected claim IDs are queued at the claim strobe, popped on claim_valid.
module tb_plic_target_core;

  localparam int NS = 8;
  localparam int PW = 3;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    req;
  logic [NS-1:0]    ready;
  logic [NS*PW-1:0] prio;
  logic [NS-1:0]    en;
  logic [PW-1:0]    thr;
  logic             claim;
  logic [IW-1:0]    claim_id;
  logic             claim_valid;
  logic             complete;
  logic [IW-1:0]    complete_id;
  logic [NS-1:0]    pending;
  logic             notif;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] sb [$];

  always #5 clk = ~clk;

  plic_target_core #(
    .NUM_SOURCES   (NS),
    .PRIORITY_WIDTH(PW),
    .ID_WIDTH      (IW)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .interrupt_source_request_i(req),
    .interrupt_target_ready_o  (ready),
    .source_priority_i         (prio),
    .source_enable_i           (en),
    .target_threshold_i        (thr),
    .claim_i                   (claim),
    .claim_id_o                (claim_id),
    .claim_valid_o             (claim_valid),
    .complete_i                (complete),
    .complete_id_i             (complete_id),
    .pending_o                 (pending),
    .interrupt_notification_o  (notif)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input int id, input logic [PW-1:0] p);
    prio[(id-1)*PW +: PW] = p;
  endtask

  task automatic do_claim(input logic [IW-1:0] exp);
    logic [IW-1:0] e;
    claim = 1'b1;
    sb.push_back(exp);
    step();
    claim = 1'b0;
    chk("claim_valid", 32'(claim_valid), 1);
    if (claim_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("claim_id", 32'(claim_id), 32'(e));
    end
  endtask

  task automatic do_complete(input logic [IW-1:0] id);
    complete    = 1'b1;
    complete_id = id;
    step();
    complete    = 1'b0;
    complete_id = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = '0; prio = '0; en = '1; thr = '0;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'hFF);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_notif", 32'(notif), 0);
    chk("rst_claim_id", 32'(claim_id), 0);
    chk("rst_claim_valid", 32'(claim_valid), 0);

    // single source flow
    set_prio(3, 5); thr = 3'd2;
    req = 8'h04;
    step();
    chk("s3_pending", 32'(pending), 32'h04);
    chk("s3_ready", 32'(ready), 32'hFB);
    chk("s3_notif_e0", 32'(notif), 0);
    step();
    chk("s3_notif_e1", 32'(notif), 0);
    step();
    chk("s3_notif_e2", 32'(notif), 1);
    do_claim(4'd3);
    chk("s3_pend_clr", 32'(pending), 0);
    chk("s3_ready_srv", 32'(ready), 32'hFB);
    step();
    chk("s3_notif_drop", 32'(notif), 0);
    chk("s3_valid_pulse", 32'(claim_valid), 0);
    chk("s3_id_hold", 32'(claim_id), 3);
    req = '0;
    do_complete(4'd3);
    chk("s3_ready_back", 32'(ready), 32'hFF);

    // priority ordering and back-to-back claim
    prio = '0;
    set_prio(2, 4); set_prio(6, 4); set_prio(5, 6);
    req = 8'h32;
    step();
    chk("ord_pending", 32'(pending), 32'h32);
    step();
    do_claim(4'd5);
    do_claim(4'd0);
    step();
    do_claim(4'd2);
    step();
    do_claim(4'd6);
    chk("ord_pend_clr", 32'(pending), 0);
    chk("ord_ready", 32'(ready), 32'hCD);
    req = '0;
    do_complete(4'd5);
    do_complete(4'd2);
    do_complete(4'd6);
    chk("ord_ready_back", 32'(ready), 32'hFF);

    // threshold equal to priority
    prio = '0;
    set_prio(4, 3); thr = 3'd3;
    req = 8'h08;
    step(); step(); step();
    chk("thr_notif", 32'(notif), 0);
    do_claim(4'd4);
    chk("thr_ready", 32'(ready), 32'hF7);
    req = '0;
    do_complete(4'd4);
    chk("thr_ready_back", 32'(ready), 32'hFF);

    // priority 0 never claimable
    prio = '0;
    req = 8'h40;
    step(); step();
    chk("p0_pending", 32'(pending), 32'h40);
    do_claim(4'd0);
    chk("p0_pend_kept", 32'(pending), 32'h40);
    req = '0;
    do_complete(4'd7);
    chk("p0_cmp_ignored", 32'(pending), 32'h40);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_ready", 32'(ready), 32'hFF);

    // completes of idle and out-of-range IDs
    do_complete(4'd7);
    chk("cmp7_ready", 32'(ready), 32'hFF);
    do_complete(4'd9);
    chk("cmp9_ready", 32'(ready), 32'hFF);
    chk("cmp9_pending", 32'(pending), 0);

    // claim 1 with complete 2 on the same edge
    prio = '0;
    set_prio(1, 2); set_prio(2, 7); thr = 3'd0;
    req = 8'h03;
    step(); step();
    do_claim(4'd2);
    req = 8'h01;
    step();
    complete = 1'b1; complete_id = 4'd2;
    do_claim(4'd1);
    complete = 1'b0; complete_id = '0;
    chk("cc_ready", 32'(ready), 32'hFE);
    chk("cc_pending", 32'(pending), 0);

    // reset mid-operation with strobes high
    req = 8'h02;
    step();
    chk("mid_pending", 32'(pending), 32'h02);
    rst = 1'b1; claim = 1'b1; complete = 1'b1; complete_id = 4'd1;
    step();
    rst = 1'b0; claim = 1'b0; complete = 1'b0; complete_id = '0;
    req = '0;
    chk("mid_ready", 32'(ready), 32'hFF);
    chk("mid_pending_clr", 32'(pending), 0);
    chk("mid_claim_id", 32'(claim_id), 0);
    chk("mid_claim_valid", 32'(claim_valid), 0);
    chk("mid_notif", 32'(notif), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
